// File: rtl/ex_mem_stage_pkg.sv
// rtl/ex_mem_stage_pkg.sv - shared widths and buffer-state encodings for the EX/MEM stage (CBNZ_EN selects CBNZ support in the top)
package ex_mem_stage_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int REG_W_DEF  = 5;

  // memRead, memWrite, regWrite, memToReg
  localparam int CTRL_W = 4;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_FULL  = 2'b10
  } buf_state_e;

endpackage

// File: rtl/ex_mem_stage_skid_buffer.sv
// rtl/ex_mem_stage_skid_buffer.sv - two-entry valid/ready skid buffer with squash
module ex_mem_stage_skid_buffer
  import ex_mem_stage_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  buf_state_e       state, state_next;
  logic [WIDTH-1:0] head_q, tail_q;
  logic             accept, pop;
  logic             load_head, load_tail, shift;

  // Both handshake outputs decode the state flop only, so ready never depends on out_ready.
  assign in_ready  = (state != BUF_FULL);
  assign out_valid = (state != BUF_EMPTY);
  assign out_data  = head_q;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BUF_EMPTY;
    else       state <= state_next;
  end

  // Next state and entry-steering strobes; flush wins over any accept or pop.
  always_comb begin
    state_next = state;
    load_head  = 1'b0;
    load_tail  = 1'b0;
    shift      = 1'b0;
    case (state)
      BUF_EMPTY: begin
        if (accept) begin
          state_next = BUF_ONE;
          load_head  = 1'b1;
        end
      end
      BUF_ONE: begin
        if (accept && pop) begin
          load_head = 1'b1;
        end else if (accept) begin
          state_next = BUF_FULL;
          load_tail  = 1'b1;
        end else if (pop) begin
          state_next = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (pop) begin
          state_next = BUF_ONE;
          shift      = 1'b1;
        end
      end
      default: state_next = BUF_EMPTY;
    endcase
    if (flush) state_next = BUF_EMPTY;
  end

  // Entry storage: head drives the outputs, tail holds the skid entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head)  head_q <= in_data;
      else if (shift) head_q <= tail_q;
      if (load_tail)  tail_q <= in_data;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM stage: branch resolution, target adder and buffered MEM bundle (CBNZ_EN adds branchNot)
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] aluResult,
  input  logic              aluZero,
  input  logic [DATA_W-1:0] storeData,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] brOffset,
  input  logic [REG_W-1:0]  rd,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              regWrite,
  input  logic              memToReg,
  input  logic              branch,
  input  logic              uncondBranch,
`ifdef CBNZ_EN
  input  logic              branchNot,
`endif
  input  logic              flush,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outAluResult,
  output logic [DATA_W-1:0] outStoreData,
  output logic [REG_W-1:0]  outRd,
  output logic              outMemRead,
  output logic              outMemWrite,
  output logic              outRegWrite,
  output logic              outMemToReg,
  output logic              pcSrc,
  output logic [DATA_W-1:0] branchTarget
);

  localparam int BUNDLE_W = 2 * DATA_W + REG_W + CTRL_W;

  logic [BUNDLE_W-1:0] bundle_in, bundle_out;
  logic                accept, taken;
  logic [DATA_W-1:0]   target_next;

  // Branch-only bundles still travel through the buffer as no-ops.
  assign bundle_in = {aluResult, storeData, rd, memRead, memWrite, regWrite, memToReg};
  assign {outAluResult, outStoreData, outRd,
          outMemRead, outMemWrite, outRegWrite, outMemToReg} = bundle_out;

  assign accept = inValid && inReady;

`ifdef CBNZ_EN
  assign taken = uncondBranch || (branch && (aluZero ^ branchNot));
`else
  assign taken = uncondBranch || (branch && aluZero);
`endif

  // Offset is in words; the sum wraps modulo 2^DATA_W.
  assign target_next = pc + (brOffset << 2);

  ex_mem_stage_skid_buffer #(
    .WIDTH(BUNDLE_W)
  ) u_skid_buffer (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (inValid),
    .in_ready (inReady),
    .in_data  (bundle_in),
    .out_valid(outValid),
    .out_ready(outReady),
    .out_data (bundle_out)
  );

  // One-cycle redirect pulse per taken accept; flush does not cancel it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcSrc        <= 1'b0;
      branchTarget <= '0;
    end else begin
      pcSrc <= accept && taken;
      if (accept && taken) branchTarget <= target_next;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - randomized and directed self-checking bench for ex_mem_stage (CBNZ_EN adds a CBNZ test)
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid, inReady, aluZero, memRead, memWrite, regWrite, memToReg;
  logic        branch, uncondBranch, branchNot, flush, outValid, outReady;
  logic [63:0] aluResult, storeData, pc, brOffset;
  logic [4:0]  rd;
  logic [63:0] outAluResult, outStoreData, branchTarget;
  logic [4:0]  outRd;
  logic        outMemRead, outMemWrite, outRegWrite, outMemToReg, pcSrc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] alu;
    logic [63:0] sd;
    logic [4:0]  rd;
    logic [3:0]  ctl;
  } bundle_t;

  bundle_t     q[$];
  logic        exp_pcsrc;
  logic [63:0] exp_tgt;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .aluResult(aluResult), .aluZero(aluZero), .storeData(storeData), .pc(pc),
    .brOffset(brOffset), .rd(rd), .memRead(memRead), .memWrite(memWrite),
    .regWrite(regWrite), .memToReg(memToReg), .branch(branch),
    .uncondBranch(uncondBranch),
`ifdef CBNZ_EN
    .branchNot(branchNot),
`endif
    .flush(flush), .outValid(outValid), .outReady(outReady),
    .outAluResult(outAluResult), .outStoreData(outStoreData), .outRd(outRd),
    .outMemRead(outMemRead), .outMemWrite(outMemWrite), .outRegWrite(outRegWrite),
    .outMemToReg(outMemToReg), .pcSrc(pcSrc), .branchTarget(branchTarget)
  );

  task automatic drive_idle();
    inValid = 0; aluZero = 0; memRead = 0; memWrite = 0; regWrite = 0; memToReg = 0;
    branch = 0; uncondBranch = 0; branchNot = 0; flush = 0; outReady = 1;
    aluResult = 0; storeData = 0; pc = 0; brOffset = 0; rd = 0;
  endtask

  task automatic model_clear();
    q.delete();
    exp_pcsrc = 0;
    exp_tgt = 0;
  endtask

  // Advances one clock and applies the behavioural model: a FIFO of at most two bundles.
  task automatic tick();
    logic    acc, pop, tk, zero_eff;
    bundle_t b;
    acc = inValid && (q.size() < 2);
    pop = (q.size() > 0) && outReady;
`ifdef CBNZ_EN
    zero_eff = aluZero != branchNot;
`else
    zero_eff = aluZero;
`endif
    tk = uncondBranch || (branch && zero_eff);
    b.alu = aluResult; b.sd = storeData; b.rd = rd;
    b.ctl = {memRead, memWrite, regWrite, memToReg};
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    exp_pcsrc = acc && tk;
    if (acc && tk) exp_tgt = pc + brOffset * 64'd4;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got %0b exp 0", outValid); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got %0b exp 1", inReady); end
    checks++; if (pcSrc !== 1'b0) begin errors++; $display("FAIL reset_pcSrc got %0b exp 0", pcSrc); end
    checks++; if (branchTarget !== 64'd0) begin errors++; $display("FAIL reset_target got %h exp 0", branchTarget); end
    checks++;
    if ({outAluResult, outStoreData, outRd, outMemRead, outMemWrite, outRegWrite, outMemToReg} !== '0) begin
      errors++; $display("FAIL reset_outdata got %h/%h/%0d exp 0", outAluResult, outStoreData, outRd);
    end
    reset = 0;
  endtask

  task automatic test_single();
    drive_idle();
    inValid = 1; aluResult = 64'h10; regWrite = 1; rd = 5'd7;
    tick();
    checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", outValid); end
    checks++; if (outAluResult !== 64'h10) begin errors++; $display("FAIL single_alu got %h exp 10", outAluResult); end
    checks++; if (outRegWrite !== 1'b1 || outRd !== 5'd7) begin errors++; $display("FAIL single_ctl got rw=%0b rd=%0d exp rw=1 rd=7", outRegWrite, outRd); end
    inValid = 0;
    tick();
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL single_empty got %0b exp 0", outValid); end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_seq [3];
    exp_seq[0] = 64'hA0; exp_seq[1] = 64'hA1; exp_seq[2] = 64'hA2;
    drive_idle();
    outReady = 0; inValid = 1;
    for (int i = 0; i < 3; i++) begin
      aluResult = exp_seq[i];
      checks++;
      if (inReady !== (i < 2)) begin errors++; $display("FAIL bp_inReady_%0d got %0b exp %0b", i, inReady, (i < 2)); end
      if (i < 2) tick();
    end
    outReady = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (outValid !== 1'b1 || outAluResult !== exp_seq[i]) begin
        errors++; $display("FAIL bp_drain_%0d got v=%0b %h exp v=1 %h", i, outValid, outAluResult, exp_seq[i]);
      end
      tick();
      if (i == 1) inValid = 0;
    end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b exp 0", outValid); end
  endtask

  task automatic test_branch();
    logic [63:0] pcs  [4];
    logic [63:0] offs [4];
    logic [63:0] tgts [4];
    logic [3:0]  zero_v, unc_v, tk_v;
    pcs[0] = 64'h100; offs[0] = 64'd3; tgts[0] = 64'h10C;
    pcs[1] = 64'h100; offs[1] = 64'd3; tgts[1] = 64'h10C;
    pcs[2] = 64'h8;   offs[2] = 64'hFFFF_FFFF_FFFF_FFFE; tgts[2] = 64'h0;
    pcs[3] = 64'hFFFF_FFFF_FFFF_FFFC; offs[3] = 64'd1; tgts[3] = 64'h0;
    zero_v = 4'b0001; unc_v = 4'b1100; tk_v = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      drive_idle();
      inValid = 1; pc = pcs[i]; brOffset = offs[i];
      branch = !unc_v[i]; uncondBranch = unc_v[i]; aluZero = zero_v[i];
      tick();
      checks++;
      if (pcSrc !== tk_v[i]) begin errors++; $display("FAIL br_pcSrc_%0d got %0b exp %0b", i, pcSrc, tk_v[i]); end
      if (tk_v[i]) begin
        checks++;
        if (branchTarget !== tgts[i]) begin errors++; $display("FAIL br_target_%0d got %h exp %h", i, branchTarget, tgts[i]); end
      end
      drive_idle();
      tick();
      checks++; if (pcSrc !== 1'b0) begin errors++; $display("FAIL br_pulse_%0d got %0b exp 0", i, pcSrc); end
    end
  endtask

  task automatic test_flush();
    drive_idle();
    outReady = 0; inValid = 1; aluResult = 64'h55;
    tick(); tick();
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL flush_full got %0b exp 0", inReady); end
    inValid = 0; flush = 1;
    tick();
    checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin errors++; $display("FAIL flush_empty got v=%0b r=%0b exp v=0 r=1", outValid, inReady); end
    inValid = 1; uncondBranch = 1; pc = 64'h40; brOffset = 64'd4; flush = 1;
    tick();
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL flush_acc_valid got %0b exp 0", outValid); end
    checks++; if (pcSrc !== 1'b1 || branchTarget !== 64'h50) begin errors++; $display("FAIL flush_pcSrc got %0b %h exp 1 50", pcSrc, branchTarget); end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    drive_idle();
    outReady = 0; inValid = 1; aluResult = 64'h77; uncondBranch = 1; pc = 64'h200; brOffset = 64'd1;
    tick(); tick();
    checks++; if (pcSrc !== 1'b1 || outValid !== 1'b1) begin errors++; $display("FAIL rmid_pre got p=%0b v=%0b exp 1 1", pcSrc, outValid); end
    reset = 1;
    #1;
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1 || pcSrc !== 1'b0 || branchTarget !== 64'd0 || outAluResult !== 64'd0) begin
      errors++; $display("FAIL rmid_async got v=%0b r=%0b p=%0b t=%h a=%h exp 0 1 0 0 0", outValid, inReady, pcSrc, branchTarget, outAluResult);
    end
    drive_idle();
    model_clear();
    #2 reset = 0;
    tick();
    checks++; if (pcSrc !== 1'b0 || outValid !== 1'b0) begin errors++; $display("FAIL rmid_after got p=%0b v=%0b exp 0 0", pcSrc, outValid); end
  endtask

`ifdef CBNZ_EN
  task automatic test_cbnz();
    drive_idle();
    inValid = 1; branch = 1; branchNot = 1; aluZero = 0; pc = 64'h20; brOffset = 64'd2;
    tick();
    checks++; if (pcSrc !== 1'b1 || branchTarget !== 64'h28) begin errors++; $display("FAIL cbnz got %0b %h exp 1 28", pcSrc, branchTarget); end
    drive_idle();
    tick();
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      checks++;
      if (outValid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_outValid cyc %0d got %0b exp %0b", n, outValid, q.size() > 0); end
      checks++;
      if (inReady !== (q.size() < 2)) begin errors++; $display("FAIL rnd_inReady cyc %0d got %0b exp %0b", n, inReady, q.size() < 2); end
      checks++;
      if (pcSrc !== exp_pcsrc) begin errors++; $display("FAIL rnd_pcSrc cyc %0d got %0b exp %0b", n, pcSrc, exp_pcsrc); end
      if (exp_pcsrc) begin
        checks++;
        if (branchTarget !== exp_tgt) begin errors++; $display("FAIL rnd_target cyc %0d got %h exp %h", n, branchTarget, exp_tgt); end
      end
      if (q.size() > 0) begin
        checks++;
        if ({outAluResult, outStoreData, outRd, outMemRead, outMemWrite, outRegWrite, outMemToReg} !==
            {q[0].alu, q[0].sd, q[0].rd, q[0].ctl}) begin
          errors++; $display("FAIL rnd_head cyc %0d got %h rd=%0d exp %h rd=%0d", n, outAluResult, outRd, q[0].alu, q[0].rd);
        end
      end
      inValid = $urandom_range(0, 3) != 0;
      outReady = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 15) == 0;
      aluResult = {$urandom, $urandom}; storeData = {$urandom, $urandom};
      pc = {$urandom, $urandom}; brOffset = {$urandom, $urandom};
      rd = 5'($urandom);
      {memRead, memWrite, regWrite, memToReg} = 4'($urandom);
      aluZero = 1'($urandom); branch = 1'($urandom); branchNot = 1'($urandom);
      uncondBranch = $urandom_range(0, 3) == 0;
      tick();
    end
    drive_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_branch();
    test_flush();
    test_reset_mid();
`ifdef CBNZ_EN
    test_cbnz();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM boundary stage of the 64-bit LEGv8 datapath. Sits directly downstream of the ALU and captures its result and zero flag together with the instruction's memory and writeback controls. Resolves conditional and unconditional branches and computes the branch target. Presents a registered, valid/ready-handshaked bundle to the memory stage through a two-entry skid buffer so memory back-pressure never drops an ALU result.

## Interface
Parameters:
- DATA_W, 64, datapath width of result, store data, PC
- REG_W, 5, destination register index width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- inValid  in  1  EX bundle valid
- inReady  out  1  stage can accept a bundle this cycle
- aluResult  in  DATA_W  ALU resultOP
- aluZero  in  1  ALU zero flag
- storeData  in  DATA_W  register value for STUR
- pc  in  DATA_W  PC of the EX instruction
- brOffset  in  DATA_W  sign-extended branch offset in words
- rd  in  REG_W  destination register
- memRead, memWrite, regWrite, memToReg  in  1 each  passed-through controls
- branch  in  1  conditional branch (CBZ)
- uncondBranch  in  1  unconditional branch (B)
- flush  in  1  hazard-unit squash of both buffer entries
- outValid  out  1  MEM bundle valid
- outReady  in  1  MEM stage accepts
- outAluResult, outStoreData  out  DATA_W  registered bundle data
- outRd  out  REG_W; outMemRead, outMemWrite, outRegWrite, outMemToReg  out  1 each
- pcSrc  out  1  one-cycle redirect pulse
- branchTarget  out  DATA_W  redirect address, valid when pcSrc=1

## Operation
- Accept: inValid && inReady. Bundle fields written into buffer entry; head entry drives out*.
- Buffer states: EMPTY, ONE, FULL (two entries).
  - EMPTY: accept -> ONE.
  - ONE: accept && !(outValid&&outReady) -> FULL; !accept && pop -> EMPTY; accept && pop -> ONE (new entry becomes head).
  - FULL: pop -> ONE; no accept possible.
- inReady = (state != FULL), registered (decoded from state flop only, no combinational path from outReady).
- outValid = (state != EMPTY).
- Branch target: branchTarget = pc + (brOffset << 2), modulo 2^DATA_W, wrap-around ignored.
- Taken: uncondBranch || (branch && aluZero). On accept of a taken bundle, pcSrc asserts for exactly the next cycle with the registered target.
- Branch-only bundles (regWrite=0, memRead=0, memWrite=0) still enter the buffer as no-ops.
- flush: state -> EMPTY next cycle, regardless of accept/pop that cycle. A same-cycle taken accept still produces pcSrc. flush does not suppress a pcSrc already in flight.
- Simultaneous accept and pop in FULL cannot occur (inReady=0).

## Timing
- Latency EX accept -> outValid: 1 cycle.
- pcSrc: 1 cycle after accept, width 1 cycle.
- Throughput: 1 bundle/cycle while outReady=1.
- Reset values: state EMPTY, outValid 0, inReady 1, pcSrc 0, branchTarget 0, all out* data/controls 0.
- Reset mid-operation: buffered bundles discarded, no pcSrc emitted afterwards.
- Out data stable while outValid && !outReady.

## Configuration
- CBNZ_EN defined: extra input branchNot (1 bit). Taken = uncondBranch || (branch && (aluZero ^ branchNot)), supporting CBNZ.
- Undefined: port absent; only CBZ and B resolved.

## Structure
- Shared package/header: DATA_W, REG_W defaults, control-bundle field widths, buffer-state encodings (EMPTY=2'b00, ONE=2'b01, FULL=2'b10).
- One sub-module: skid_buffer (two-entry valid/ready buffer, width parameter) instantiated for the concatenated bundle. Branch resolution and target adder stay in the top.

## Test plan
- Single bundle aluResult=0x10, regWrite=1, outReady=1 -> outValid high one cycle later with outAluResult=0x10, then EMPTY.
- outReady=0, three inValid cycles -> first two accepted, inReady=0 on third; release outReady -> bundles drain in order, none lost.
- CBZ pc=0x100, brOffset=3, aluZero=1 -> pcSrc=1 one cycle later, branchTarget=0x10C. Same with aluZero=0 -> pcSrc stays 0.
- B pc=0x8, brOffset=-2 (0xFFFF_FFFF_FFFF_FFFE) -> branchTarget=0x0. pc=0xFFFF_FFFF_FFFF_FFFC, offset=1 -> target wraps to 0x0.
- FULL state, assert flush -> next cycle outValid=0, inReady=1. Assert reset mid-drain -> all outputs at reset values immediately.
- With CBNZ_EN: branch=1, branchNot=1, aluZero=0 -> pcSrc=1.
